// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder: TCK/TMS/TDI/TRST oversampled in the clk domain, 1149.1 FSM, IR, BYPASS, IDCODE, user DR.
// User DR and its ports are built only when JTAG_TAP_USER_DR_EN is defined; otherwise user outputs are tied low.
module jtag_tap_sampled #(
  parameter int unsigned          IR_WIDTH      = 5,
  parameter logic [31:0]          IDCODE_VAL    = 32'h1000_0001,
  parameter int unsigned          USER_DR_WIDTH = 41,
  parameter int unsigned          SYNC_STAGES   = 2,
  parameter logic [IR_WIDTH-1:0]  INSTR_USER    = IR_WIDTH'(5'h11)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
  input  logic                     trst,
  output logic                     tdo,
  output logic                     tdo_oe,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  output logic                     user_capture,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic                     user_update,
  output logic [USER_DR_WIDTH-1:0] user_update_data
);

  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PA_DR  = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PA_IR  = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic                        tck_prev_q;
  logic                        tck_s, tms_s, tdi_s, trst_s;
  logic                        tck_rise, tck_fall, step;

  logic [3:0]                  state_q, state_d, next_state;
  logic [IR_WIDTH-1:0]         ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]         ir_value_q, ir_value_d;
  logic [31:0]                 idcode_sr_q, idcode_sr_d;
  logic                        bypass_q, bypass_d;
  logic                        tdo_q, tdo_d;
  logic                        tdo_oe_q, tdo_oe_d;
  logic                        sel_idcode, sel_user, user_lsb;

  // All four pins share one chain so tms/tdi stay aligned with the tck edge they belong to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q     <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], {trst, tdi, tms, tck}};
      tck_prev_q <= tck_s;
    end
  end

  assign {trst_s, tdi_s, tms_s, tck_s} = sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;
  assign step     = tck_rise & ~trst_s;

  always_comb begin
    next_state = state_q;
    case (state_q)
      TLR:     next_state = tms_s ? TLR    : RTI;
      RTI:     next_state = tms_s ? SEL_DR : RTI;
      SEL_DR:  next_state = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = tms_s ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms_s ? UPD_DR : PA_DR;
      PA_DR:   next_state = tms_s ? EX2_DR : PA_DR;
      EX2_DR:  next_state = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms_s ? SEL_DR : RTI;
      SEL_IR:  next_state = tms_s ? TLR    : CAP_IR;
      CAP_IR:  next_state = tms_s ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms_s ? UPD_IR : PA_IR;
      PA_IR:   next_state = tms_s ? EX2_IR : PA_IR;
      EX2_IR:  next_state = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  next_state = tms_s ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  assign sel_idcode = (ir_value_q == IR_IDCODE);

  always_comb begin
    state_d     = state_q;
    ir_shift_d  = ir_shift_q;
    ir_value_d  = ir_value_q;
    idcode_sr_d = idcode_sr_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;
    if (trst_s) begin
      state_d    = TLR;
      ir_value_d = IR_IDCODE;
    end else if (tck_rise) begin
      state_d = next_state;
      // Actions belong to the state being left, not the one being entered.
      case (state_q)
        CAP_IR: ir_shift_d = IR_IDCODE;
        SH_IR: begin
          ir_shift_d               = ir_shift_q >> 1;
          ir_shift_d[IR_WIDTH-1]   = tdi_s;
        end
        UPD_IR: ir_value_d = ir_shift_q;
        CAP_DR: begin
          if (sel_idcode)     idcode_sr_d = IDCODE_VAL;
          else if (!sel_user) bypass_d    = 1'b0;
        end
        SH_DR: begin
          if (sel_idcode)     idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
          else if (!sel_user) bypass_d    = tdi_s;
        end
        default: ;
      endcase
      if (next_state == TLR) ir_value_d = IR_IDCODE;
    end else if (tck_fall) begin
      if (state_q == SH_IR) begin
        tdo_d    = ir_shift_q[0];
        tdo_oe_d = 1'b1;
      end else if (state_q == SH_DR) begin
        tdo_d    = sel_idcode ? idcode_sr_q[0] : (sel_user ? user_lsb : bypass_q);
        tdo_oe_d = 1'b1;
      end else begin
        tdo_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= TLR;
      ir_shift_q  <= '0;
      ir_value_q  <= IR_IDCODE;
      idcode_sr_q <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_shift_q  <= ir_shift_d;
      ir_value_q  <= ir_value_d;
      idcode_sr_q <= idcode_sr_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_oe_q    <= tdo_oe_d;
    end
  end

  assign tdo       = tdo_q;
  assign tdo_oe    = tdo_oe_q;
  assign tap_state = state_q;
  assign ir_value  = ir_value_q;

`ifdef JTAG_TAP_USER_DR_EN
  logic [USER_DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic                     user_capture_q, user_update_q;

  assign sel_user = (ir_value_q == INSTR_USER);

  always_comb begin
    user_sr_d = user_sr_q;
    if (step && sel_user) begin
      if (state_q == CAP_DR) begin
        user_sr_d = user_capture_data;
      end else if (state_q == SH_DR) begin
        user_sr_d                    = user_sr_q >> 1;
        user_sr_d[USER_DR_WIDTH-1]   = tdi_s;
      end
    end
  end

  // Pulses are raised on the same clk that samples/holds the user register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      user_sr_q      <= '0;
      user_capture_q <= 1'b0;
      user_update_q  <= 1'b0;
    end else begin
      user_sr_q      <= user_sr_d;
      user_capture_q <= step && sel_user && (state_q == CAP_DR);
      user_update_q  <= step && sel_user && (state_q == UPD_DR);
    end
  end

  assign user_lsb         = user_sr_q[0];
  assign user_capture     = user_capture_q;
  assign user_update      = user_update_q;
  assign user_update_data = user_sr_q;
`else
  logic unused_user;
  assign unused_user      = ^{user_capture_data, INSTR_USER};
  assign sel_user         = 1'b0;
  assign user_lsb         = 1'b0;
  assign user_capture     = 1'b0;
  assign user_update      = 1'b0;
  assign user_update_data = '0;
`endif

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Bench for jtag_tap_sampled: state-walk table, directed scans, reset corners and a randomized run against a reference TAP model.
module tb_jtag_tap_sampled;
  logic        clk = 1'b0, rstn = 1'b0, tck = 1'b0, tms = 1'b0, tdi = 1'b0, trst = 1'b0;
  logic        tdo, tdo_oe, user_capture, user_update;
  logic [3:0]  tap_state;
  logic [4:0]  ir_value;
  logic [40:0] user_capture_data = '0;
  logic [40:0] user_update_data;

  int errors = 0, checks = 0;
  int ph_lo = 5, ph_hi = 5;
  logic last_tdo;

  always #5 clk = ~clk;

  jtag_tap_sampled dut (
    .clk(clk), .rstn(rstn), .tck(tck), .tms(tms), .tdi(tdi), .trst(trst),
    .tdo(tdo), .tdo_oe(tdo_oe), .tap_state(tap_state), .ir_value(ir_value),
    .user_capture(user_capture), .user_capture_data(user_capture_data),
    .user_update(user_update), .user_update_data(user_update_data)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  int cap_cnt = 0, upd_cnt = 0;
  logic [40:0] upd_seen = '0;
  always @(negedge clk) begin
    if (user_capture === 1'b1) cap_cnt++;
    if (user_update === 1'b1) begin
      upd_cnt++;
      upd_seen = user_update_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference TAP model ----------------
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_st;
  logic [4:0]  m_ir, m_irsh;
  logic [63:0] m_dr;
  logic        m_tdo, m_oe;
  int          m_cap = 0, m_upd = 0;
  logic [40:0] m_upd_data = '0;
  logic [8:0]  exp_q [$];

  initial begin
    //        0     1     2     3     4     5     6     7     8     9     A     B     C     D     E     F
    nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6, 4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4, 4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
  end

  function automatic logic m_user_sel();
`ifdef JTAG_TAP_USER_DR_EN
    return m_ir == 5'h11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_st = 4'hF; m_ir = 5'h01; m_irsh = '0; m_dr = '0; m_tdo = 1'b0; m_oe = 1'b0;
  endtask

  task automatic model_rise(input logic t_ms, input logic t_di);
    int len;
    len = (m_ir == 5'h01) ? 32 : (m_user_sel() ? 41 : 1);
    case (m_st)
      4'hE: m_irsh = 5'b00001;
      4'hA: m_irsh = {t_di, m_irsh[4:1]};
      4'hD: m_ir = m_irsh;
      4'h6: begin
        if (m_ir == 5'h01) m_dr = 64'h1000_0001;
        else if (m_user_sel()) begin m_dr = {23'b0, user_capture_data}; m_cap++; end
        else m_dr = '0;
      end
      4'h2: begin m_dr = m_dr >> 1; m_dr[len-1] = t_di; end
      4'h5: if (m_user_sel()) begin m_upd++; m_upd_data = m_dr[40:0]; end
      default: ;
    endcase
    m_st = t_ms ? nxt1[m_st] : nxt0[m_st];
    if (m_st == 4'hF) m_ir = 5'h01;
  endtask

  task automatic model_fall();
    if (m_st == 4'hA)      begin m_tdo = m_irsh[0]; m_oe = 1'b1; end
    else if (m_st == 4'h2) begin m_tdo = m_dr[0];   m_oe = 1'b1; end
    else                   m_oe = 1'b0;
  endtask

  // One TCK period: low phase, tdo sampled just before the rise, high phase.
  task automatic jbit(input logic t_ms, input logic t_di);
    logic [8:0] e;
    tms = t_ms; tdi = t_di;
    wclk(ph_lo);
    chk("tdo", tdo, m_tdo);
    chk("tdo_oe", tdo_oe, m_oe);
    last_tdo = tdo;
    model_rise(t_ms, t_di);
    exp_q.push_back({m_st, m_ir});
    tck = 1'b1;
    wclk(ph_hi);
    e = exp_q.pop_front();
    chk("tap_state", tap_state, e[8:5]);
    chk("ir_value", ir_value, e[4:0]);
    tck = 1'b0;
    model_fall();
  endtask

  task automatic load_ir(input logic [4:0] val, output logic [4:0] cap_out);
    jbit(1, 0); jbit(1, 0); jbit(0, 0); jbit(0, 0);
    for (int i = 0; i < 5; i++) begin
      jbit(i == 4, val[i]);
      cap_out[i] = last_tdo;
    end
    jbit(1, 0); jbit(0, 0);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    dout = '0;
    jbit(1, 0); jbit(0, 0); jbit(0, 0);
    for (int i = 0; i < n; i++) begin
      jbit(i == n - 1, din[i]);
      dout[i] = last_tdo;
    end
    jbit(1, 0); jbit(0, 0);
  endtask

  typedef struct { logic t_ms; logic t_di; logic [3:0] st; } vec_t;
  vec_t tbl [$];

  initial begin
    logic [63:0] d;
    logic [4:0]  irc;
    logic [40:0] udat;
    int          u0, c0;

    tbl.push_back('{0,1,4'hC}); tbl.push_back('{0,0,4'hC}); tbl.push_back('{1,1,4'h7}); tbl.push_back('{0,0,4'h6});
    tbl.push_back('{0,1,4'h2}); tbl.push_back('{0,1,4'h2}); tbl.push_back('{1,0,4'h1}); tbl.push_back('{0,1,4'h3});
    tbl.push_back('{0,0,4'h3}); tbl.push_back('{1,1,4'h0}); tbl.push_back('{0,0,4'h2}); tbl.push_back('{1,1,4'h1});
    tbl.push_back('{1,0,4'h5}); tbl.push_back('{1,0,4'h7}); tbl.push_back('{1,0,4'h4}); tbl.push_back('{0,1,4'hE});
    tbl.push_back('{0,0,4'hA}); tbl.push_back('{1,1,4'h9}); tbl.push_back('{0,0,4'hB}); tbl.push_back('{1,1,4'h8});
    tbl.push_back('{0,0,4'hA}); tbl.push_back('{1,1,4'h9}); tbl.push_back('{1,0,4'hD}); tbl.push_back('{1,0,4'h7});
    tbl.push_back('{0,0,4'h6}); tbl.push_back('{1,0,4'h1}); tbl.push_back('{0,0,4'h3}); tbl.push_back('{1,0,4'h0});
    tbl.push_back('{1,0,4'h5}); tbl.push_back('{1,0,4'h7}); tbl.push_back('{1,0,4'h4}); tbl.push_back('{1,0,4'hF});

    // Reset values while rstn is low
    m_reset();
    wclk(3);
    chk("rst_state", tap_state, 4'hF);
    chk("rst_ir", ir_value, 5'h01);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_tdo_oe", tdo_oe, 1'b0);
    chk("rst_pulses", {user_capture, user_update}, 2'b00);
    chk("rst_user_data", user_update_data, 41'h0);
    rstn = 1'b1;
    wclk(2);

    for (int i = 0; i < 5; i++) jbit(1, 0);
    chk("tms5_state", tap_state, 4'hF);
    chk("tms5_pulses", cap_cnt + upd_cnt, 0);

    foreach (tbl[i]) begin
      jbit(tbl[i].t_ms, tbl[i].t_di);
      chk("walk_state", tap_state, tbl[i].st);
    end
    chk("walk_ir_tlr", ir_value, 5'h01);

    // IDCODE read at the minimum supported phase length
    ph_lo = 4; ph_hi = 4;
    jbit(0, 0);
    scan_dr(64'h0, 32, d);
    chk("idcode", d[31:0], 32'h1000_0001);

    load_ir(5'h1F, irc);
    chk("ir_capture", irc, 5'b00001);
    chk("ir_1f", ir_value, 5'h1F);
    scan_dr(64'b1101, 4, d);
    chk("bypass", d[3:0], 4'b1010);
    ph_lo = 5; ph_hi = 5;

    udat = 41'h1_2345_6789A;
    user_capture_data = udat;
    c0 = cap_cnt; u0 = upd_cnt;
    load_ir(5'h11, irc);
    chk("ir_11", ir_value, 5'h11);
    scan_dr({23'b0, ~udat}, 41, d);
`ifdef JTAG_TAP_USER_DR_EN
    chk("user_tdo", d[40:0], udat);
    chk("user_cap_cnt", cap_cnt - c0, 1);
    chk("user_upd_cnt", upd_cnt - u0, 1);
    chk("user_upd_data", upd_seen, ~udat);
`else
    chk("user_as_bypass", d[40:0], {~udat[39:0], 1'b0});
    chk("user_cap_cnt", cap_cnt - c0, 0);
    chk("user_upd_cnt", upd_cnt - u0, 0);
    chk("user_upd_data", user_update_data, 41'h0);
`endif

    // trst while shifting the user DR at bit 10
    u0 = upd_cnt;
    jbit(1, 0); jbit(0, 0); jbit(0, 0);
    for (int i = 0; i < 10; i++) jbit(0, 1'($urandom_range(0, 1)));
    wclk(2);
    trst = 1'b1;
    wclk(4);
    m_st = 4'hF; m_ir = 5'h01;
    chk("trst_state", tap_state, 4'hF);
    chk("trst_ir", ir_value, 5'h01);
    trst = 1'b0;
    wclk(4);
    chk("trst_no_update", upd_cnt - u0, 0);
    jbit(0, 0);

    // rstn while shifting the user DR
    load_ir(5'h11, irc);
    u0 = upd_cnt;
    jbit(1, 0); jbit(0, 0); jbit(0, 0);
    for (int i = 0; i < 6; i++) jbit(0, 1);
    rstn = 1'b0;
    wclk(2);
    m_reset();
    chk("rstn_mid_state", tap_state, 4'hF);
    chk("rstn_mid_ir", ir_value, 5'h01);
    chk("rstn_mid_oe", {tdo_oe, tdo}, 2'b00);
    rstn = 1'b1;
    wclk(3);
    chk("rstn_no_update", upd_cnt - u0, 0);

    // Randomized run against the model
    jbit(0, 0);
    load_ir(5'h11, irc);
    for (int i = 0; i < 320; i++) begin
      ph_lo = $urandom_range(4, 10);
      ph_hi = $urandom_range(4, 10);
      if ($urandom_range(0, 7) == 0) user_capture_data = {9'($urandom), $urandom};
      if ($urandom_range(0, 60) == 0) begin
        for (int k = 0; k < 5; k++) jbit(1, 1'($urandom_range(0, 1)));
        chk("rand_tms5_tlr", tap_state, 4'hF);
        if ($urandom_range(0, 1) == 1) begin jbit(0, 0); load_ir(5'h11, irc); end
      end else begin
        jbit(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
    end
    chk("rand_cap_cnt", cap_cnt, m_cap);
    chk("rand_upd_cnt", upd_cnt, m_upd);
    chk("rand_upd_data", upd_seen, m_upd_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
